// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and defaults for the instruction/data memory
//               arbiter: FSM state encoding, streak counter width and the
//               default data-grant streak limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Consecutive data grants tolerated while an instruction fetch is waiting.
  localparam int MAXDSTREAK_DEF = 4;

  // Width of the data-grant streak counter; MAXDSTREAK must fit in it.
  localparam int STREAK_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational grant decision between the instruction and data
//               requesters. Data wins by default; an instruction request that
//               has already watched MAXDSTREAK data grants go by takes over.
// Ports       : ireq    - instruction request
//               dreq    - data request
//               dstreak - data grants issued while ireq was waiting
//               grant_d - grant the data requester
//               grant_i - grant the instruction requester
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAXDSTREAK = MAXDSTREAK_DEF
) (
  input  logic                ireq,
  input  logic                dreq,
  input  logic [STREAK_W-1:0] dstreak,
  output logic                grant_d,
  output logic                grant_i
);

  logic starved;

  // The fetch has waited long enough: the data side must yield this round.
  assign starved = ireq && (dstreak == STREAK_W'(MAXDSTREAK));

  assign grant_d = dreq && !starved;
  assign grant_i = ireq && !grant_d;

endmodule : arb_pick
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates an instruction-fetch port and a data load/store
//               port onto a single memory port. One access at a time:
//               IDLE -> IBUSY/DBUSY -> RESP -> IDLE. All outputs registered.
// Ports       : clk, reset (async, active low)
//               ireq/iadr/idone/irdata            - instruction fetch port
//               dreq/dwe/dadr/dwdata/ddone/drdata - data port
//               mreq/mwe/madr/mwdata/mrdata/mready - memory port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N          = 64,
  parameter int W          = 32,
  parameter int MAXDSTREAK = MAXDSTREAK_DEF
) (
  input  logic         clk,
  input  logic         reset,
  // instruction port
  input  logic         ireq,
  input  logic [W-1:0] iadr,
  output logic         idone,
  output logic [31:0]  irdata,
  // data port
  input  logic         dreq,
  input  logic         dwe,
  input  logic [W-1:0] dadr,
  input  logic [N-1:0] dwdata,
  output logic         ddone,
  output logic [N-1:0] drdata,
  // memory port
  output logic         mreq,
  output logic         mwe,
  output logic [W-1:0] madr,
  output logic [N-1:0] mwdata,
  input  logic [N-1:0] mrdata,
  input  logic         mready
);

  state_t              state;
  logic [STREAK_W-1:0] dstreak;
  logic                grant_d;
  logic                grant_i;

  arb_pick #(
    .MAXDSTREAK (MAXDSTREAK)
  ) u_arb_pick (
    .ireq    (ireq),
    .dreq    (dreq),
    .dstreak (dstreak),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dstreak <= '0;
      mreq    <= 1'b0;
      mwe     <= 1'b0;
      madr    <= '0;
      mwdata  <= '0;
      idone   <= 1'b0;
      ddone   <= 1'b0;
      irdata  <= '0;
      drdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          idone <= 1'b0;
          ddone <= 1'b0;
          if (grant_d) begin
            state  <= DBUSY;
            mreq   <= 1'b1;
            mwe    <= dwe;
            madr   <= dadr;
            mwdata <= dwdata;
            // Only count data grants that made a fetch wait.
            if (ireq) begin
              if (dstreak != STREAK_W'(MAXDSTREAK))
                dstreak <= dstreak + 1'b1;
            end else begin
              dstreak <= '0;
            end
          end else if (grant_i) begin
            state   <= IBUSY;
            mreq    <= 1'b1;
            mwe     <= 1'b0;
            madr    <= iadr;
            mwdata  <= '0;
            dstreak <= '0;
          end else begin
            mreq <= 1'b0;
          end
        end

        // Memory-side outputs stay frozen until the memory completes.
        IBUSY: begin
          if (mready) begin
            irdata <= mrdata[31:0];
            idone  <= 1'b1;
            mreq   <= 1'b0;
            state  <= RESP;
          end
        end

        DBUSY: begin
          if (mready) begin
            drdata <= mrdata;
            ddone  <= 1'b1;
            mreq   <= 1'b0;
            state  <= RESP;
          end
        end

        // One dead cycle so requesters can drop or renew their request.
        RESP: begin
          idone <= 1'b0;
          ddone <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N, 64, data width in bits.
REQ-002 Parameter: W, 32, address width in bits.
REQ-003 Parameter: MAXDSTREAK, 4, consecutive data grants allowed while an instruction request waits.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 Port: ireq  input  1  instruction fetch request, held until idone.
REQ-007 Port: iadr  input  W  fetch address, stable while ireq=1.
REQ-008 Port: idone  output  1  one-cycle pulse; irdata valid.
REQ-009 Port: irdata  output  32  fetched instruction, mrdata[31:0].
REQ-010 Port: dreq  input  1  data access request, held until ddone.
REQ-011 Port: dwe  input  1  1 = store, 0 = load; stable while dreq=1.
REQ-012 Port: dadr  input  W  data address.
REQ-013 Port: dwdata  input  N  store data.
REQ-014 Port: ddone  output  1  one-cycle pulse; drdata valid for loads.
REQ-015 Port: drdata  output  N  load data.
REQ-016 Port: mreq  output  1  memory request, held until mready.
REQ-017 Port: mwe  output  1  memory write enable.
REQ-018 Port: madr  output  W  memory address.
REQ-019 Port: mwdata  output  N  memory write data.
REQ-020 Port: mrdata  input  N  memory read data, valid when mready=1.
REQ-021 Port: mready  input  1  memory completion, one cycle, any latency >=1.

Function
REQ-022 FSM states: IDLE, IBUSY, DBUSY, RESP; all outputs registered.
REQ-023 IDLE, dreq=1, and not (ireq=1 and dstreak=MAXDSTREAK): grant data; next DBUSY; mreq=1, mwe=dwe, madr=dadr, mwdata=dwdata.
REQ-024 IDLE, ireq=1, and data not granted per REQ-023: grant instruction; next IBUSY; mreq=1, mwe=0, madr=iadr, mwdata=0.
REQ-025 IDLE with no request: stay in IDLE; mreq=0.
REQ-026 dstreak (3 bits): increments on a data grant while ireq=1; clears to 0 on an instruction grant or on a data grant with ireq=0; saturates at MAXDSTREAK.
REQ-027 IBUSY/DBUSY: mreq, mwe, madr and mwdata are held unchanged until mready=1.
REQ-028 IBUSY with mready=1: irdata<=mrdata[31:0]; next RESP with idone=1; mreq=0.
REQ-029 DBUSY with mready=1: drdata<=mrdata (stores also capture it, and the value is don't-care to the requester); next RESP with ddone=1; mreq=0.
REQ-030 RESP lasts exactly one cycle, grants nothing, and returns to IDLE; requesters drop or renew the request during it.
REQ-031 Minimum grant-to-done latency = 2 cycles (mready on the first BUSY cycle); minimum back-to-back issue period = 3 cycles.
REQ-032 mready in IDLE or RESP is ignored.
REQ-033 irdata and drdata hold their last captured value until the next completion of the same kind.
REQ-034 At most one of idone and ddone is 1 in any cycle.

Reset
REQ-035 When reset=0: state=IDLE, dstreak=0, and mreq, mwe, madr, mwdata, idone, ddone, irdata, drdata all = 0, immediately and asynchronously.
REQ-036 A reset during IBUSY or DBUSY abandons the access; no done pulse is produced; a late mready is ignored per REQ-032.

Structure
REQ-037 Package mem_arb_pkg holds the state enum and the MAXDSTREAK default.
REQ-038 One combinational sub-module, arb_pick, computes the grant from ireq, dreq and dstreak; the FSM and registers live in mem_arbiter.

Verification
REQ-039 Single fetch: ireq=1, iadr=0x00000040, mready 3 cycles later with mrdata=0x20080005 -> madr=0x40, mwe=0; idone one cycle after mready; irdata=0x20080005.
REQ-040 Collision: ireq=dreq=1 in IDLE, dwe=1, dadr=0x100, dwdata=0xDEADBEEF -> data granted first with mwe=1, madr=0x100; instruction granted after RESP.
REQ-041 Starvation: ireq held high, dreq renewed continuously -> exactly 4 data grants, then 1 instruction grant; dstreak back to 0.
REQ-042 Latency: mready on the first BUSY cycle -> ddone two cycles after the grant edge; next grant 3 cycles after the previous one.
REQ-043 Reset mid-access: reset=0 during DBUSY, then mready=1 after release -> all outputs 0, no ddone, state IDLE.
REQ-044 Spurious mready in IDLE with no request -> mreq, idone and ddone stay 0; irdata and drdata unchanged.
